// File: rtl/amx_mouse_accum_if.sv
// amx_mouse_accum_if
//   Bundles the PS/2 movement bus, the decoder consume strobes and the pending
//   movement/button outputs of amx_mouse_accum, plus debug visibility of the
//   accumulators and the priming state.
//
//   Handshake: there is no backpressure anywhere on this bus. A packet is
//   signalled by ps2_mouse[24] changing level; the data bits are valid whenever
//   the toggle changes. consume_x / consume_y are single-cycle strobes meaning
//   "the value on mouse_x / mouse_y at this clock edge has been taken"; the
//   accumulator subtracts exactly that value on the same edge.
//
//   master : the side that drives ps2_mouse and the consume strobes
//   slave  : amx_mouse_accum
interface amx_mouse_accum_if #(
  parameter int ACC_W = 14
);
  logic [24:0]             ps2_mouse;
  logic                    consume_x;
  logic                    consume_y;
  logic signed [8:0]       mouse_x;
  logic signed [8:0]       mouse_y;
  logic                    mouse_left;
  logic                    mouse_middle;
  logic                    mouse_right;
  logic                    moved;
  logic [0:0]              dbg_state;
  logic signed [ACC_W-1:0] dbg_acc_x;
  logic signed [ACC_W-1:0] dbg_acc_y;

  modport master (
    output ps2_mouse, consume_x, consume_y,
    input  mouse_x, mouse_y, mouse_left, mouse_middle, mouse_right, moved,
    input  dbg_state, dbg_acc_x, dbg_acc_y
  );

  modport slave (
    input  ps2_mouse, consume_x, consume_y,
    output mouse_x, mouse_y, mouse_left, mouse_middle, mouse_right, moved,
    output dbg_state, dbg_acc_x, dbg_acc_y
  );
endinterface

// File: rtl/amx_mouse_accum.sv
// amx_mouse_accum
//   Feeds the AMX mouse port decoder. Integrates PS/2 X/Y deltas into
//   saturating signed accumulators, presents the pending movement clamped to
//   9-bit signed mouse_x / mouse_y, registers button levels on each packet and
//   drains an axis by the presented value whenever the decoder consumes it.
//
//   Parameters: ACC_W (accumulator width), INVERT_Y (negate PS/2 Y),
//               STALE_CYC (idle edges before stale clear, AMX_STALE_CLEAR_EN only)
//   Ports:      clk_sys, reset (async, active high), bus (amx_mouse_accum_if.slave)
//   Optional:   define AMX_STALE_CLEAR_EN to clear pending movement after
//               STALE_CYC edges with neither a packet nor a consume.
module amx_mouse_accum #(
  parameter int ACC_W    = 14,
  parameter bit INVERT_Y = 1'b1
`ifdef AMX_STALE_CLEAR_EN
  , parameter logic [23:0] STALE_CYC = 24'd2_000_000
`endif
) (
  input logic              clk_sys,
  input logic              reset,
  amx_mouse_accum_if.slave bus
);
  // Two guard bits cover acc - out + d without wrapping before saturation.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] ACC_MAX = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] ACC_MIN = {3'b111, {(ACC_W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] ZERO_S  = '0;
  localparam logic signed [ACC_W-1:0] CLAMP_HI = ACC_W'(255);
  localparam logic signed [ACC_W-1:0] CLAMP_LO = ~ACC_W'(255);
  localparam logic signed [8:0] POS255 = 9'sh0FF;
  localparam logic signed [8:0] NEG256 = 9'sh100;

  // First edge after reset only samples the toggle (ST_PRIME).
  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  function automatic logic signed [8:0] decode(input logic sgn, input logic ovf,
                                               input logic [7:0] b);
    if (ovf) return sgn ? NEG256 : POS255;
    return {sgn, b};
  endfunction

  function automatic logic signed [SUM_W-1:0] sext9(input logic signed [8:0] v);
    return {{(SUM_W-9){v[8]}}, v};
  endfunction

  function automatic logic signed [SUM_W-1:0] sext_acc(input logic signed [ACC_W-1:0] a);
    return {{2{a[ACC_W-1]}}, a};
  endfunction

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [SUM_W-1:0] s);
    if (s > ACC_MAX) return ACC_MAX[ACC_W-1:0];
    if (s < ACC_MIN) return ACC_MIN[ACC_W-1:0];
    return s[ACC_W-1:0];
  endfunction

  function automatic logic signed [8:0] clamp9(input logic signed [ACC_W-1:0] a);
    if (a > CLAMP_HI) return POS255;
    if (a < CLAMP_LO) return NEG256;
    return a[8:0];
  endfunction

  logic [0:0]              state_q, state_d;
  logic                    old_tog_q, old_tog_d;
  logic signed [ACC_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic signed [8:0]       mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [2:0]              btn_q, btn_d;   // {middle, right, left}
  logic                    moved_q, moved_d;

  logic                    pkt;
  logic [7:0]              status;
  logic signed [8:0]       dx, dy_raw, dy;
  logic signed [SUM_W-1:0] sum_x, sum_y;

  // Status bit 3 is the PS/2 always-one bit and carries no information.
  logic unused_status_b3;
  assign unused_status_b3 = bus.ps2_mouse[3];

`ifdef AMX_STALE_CLEAR_EN
  logic [23:0] idle_q, idle_d;
`endif

  always_comb begin
    state_d   = ST_RUN;
    old_tog_d = bus.ps2_mouse[24];
    pkt       = (state_q == ST_RUN) && (bus.ps2_mouse[24] != old_tog_q);
    status    = bus.ps2_mouse[7:0];

    dx     = decode(status[4], status[6], bus.ps2_mouse[15:8]);
    dy_raw = decode(status[5], status[7], bus.ps2_mouse[23:16]);
    if (INVERT_Y) dy = (dy_raw == NEG256) ? POS255 : -dy_raw;
    else          dy = dy_raw;

    // Drain and packet are merged into one saturating step so neither is lost.
    sum_x = sext_acc(acc_x_q)
          - (bus.consume_x ? sext9(mouse_x_q) : ZERO_S)
          + (pkt ? sext9(dx) : ZERO_S);
    sum_y = sext_acc(acc_y_q)
          - (bus.consume_y ? sext9(mouse_y_q) : ZERO_S)
          + (pkt ? sext9(dy) : ZERO_S);
    acc_x_d = sat(sum_x);
    acc_y_d = sat(sum_y);

    btn_d = pkt ? {status[2], status[1], status[0]} : btn_q;

`ifdef AMX_STALE_CLEAR_EN
    idle_d = '0;
    if ((state_q == ST_RUN) && !pkt && !bus.consume_x && !bus.consume_y) begin
      if (idle_q == STALE_CYC - 24'd1) begin
        acc_x_d = '0;
        acc_y_d = '0;
      end else begin
        idle_d = idle_q + 24'd1;
      end
    end
`endif

    // Outputs trail the accumulators by one edge.
    mouse_x_d = clamp9(acc_x_q);
    mouse_y_d = clamp9(acc_y_q);
    moved_d   = (acc_x_q != '0) || (acc_y_q != '0);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q   <= ST_PRIME;
      old_tog_q <= 1'b0;
      acc_x_q   <= '0;
      acc_y_q   <= '0;
      mouse_x_q <= '0;
      mouse_y_q <= '0;
      btn_q     <= '0;
      moved_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      old_tog_q <= old_tog_d;
      acc_x_q   <= acc_x_d;
      acc_y_q   <= acc_y_d;
      mouse_x_q <= mouse_x_d;
      mouse_y_q <= mouse_y_d;
      btn_q     <= btn_d;
      moved_q   <= moved_d;
    end
  end

`ifdef AMX_STALE_CLEAR_EN
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`endif

  assign bus.mouse_x      = mouse_x_q;
  assign bus.mouse_y      = mouse_y_q;
  assign bus.mouse_left   = btn_q[0];
  assign bus.mouse_right  = btn_q[1];
  assign bus.mouse_middle = btn_q[2];
  assign bus.moved        = moved_q;
  assign bus.dbg_state    = state_q;
  assign bus.dbg_acc_x    = acc_x_q;
  assign bus.dbg_acc_y    = acc_y_q;
endmodule

// File: tb/tb_amx_mouse_accum.sv
// Directed bench for amx_mouse_accum (ACC_W=14, INVERT_Y=1; STALE_CYC=16 when
// AMX_STALE_CLEAR_EN is defined). Inputs change on the falling edge, outputs
// are sampled on the falling edge after each rising edge.
module tb_amx_mouse_accum;
  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  logic tog     = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  logic signed [13:0] exp_q[$];

  always #5 clk_sys = ~clk_sys;

  amx_mouse_accum_if #(.ACC_W(14)) bus ();

  amx_mouse_accum #(
    .ACC_W(14),
    .INVERT_Y(1'b1)
`ifdef AMX_STALE_CLEAR_EN
    , .STALE_CYC(24'd16)
`endif
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus)
  );

  // One clock edge: optionally a new packet (toggle flip) and consume strobes.
  task automatic step(input logic pkt, input logic [7:0] st, input logic [7:0] xb,
                      input logic [7:0] yb, input logic cx, input logic cy);
    if (pkt) begin
      tog = ~tog;
      bus.ps2_mouse = {tog, yb, xb, st};
    end
    bus.consume_x = cx;
    bus.consume_y = cy;
    @(negedge clk_sys);
    bus.consume_x = 1'b0;
    bus.consume_y = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
  endtask

  // Reset, then let the priming edge go by.
  task automatic do_reset(input logic t);
    reset = 1'b1;
    tog = t;
    bus.ps2_mouse = {t, 24'h0};
    @(negedge clk_sys);
    reset = 1'b0;
    idle(1);
  endtask

  task automatic test_reset();
    tog = 1'b1;
    bus.ps2_mouse = {1'b1, 8'd0, 8'd20, 8'h01};
    bus.consume_x = 1'b0;
    bus.consume_y = 1'b0;
    reset = 1'b1;
    @(negedge clk_sys);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd0 || bus.mouse_y !== 9'sd0 || bus.moved !== 1'b0 ||
        bus.mouse_left !== 1'b0 || bus.dbg_state !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: x=%0d y=%0d moved=%b left=%b state=%b, required all 0",
               bus.mouse_x, bus.mouse_y, bus.moved, bus.mouse_left, bus.dbg_state);
    end
    @(negedge clk_sys);
    reset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      idle(1);
      vec_cnt++;
      if (bus.mouse_x !== 9'sd0 || bus.mouse_y !== 9'sd0 || bus.moved !== 1'b0 ||
          bus.mouse_left !== 1'b0) begin
        err_cnt++;
        $display("FAIL no_phantom cyc %0d: x=%0d y=%0d moved=%b left=%b, required 0",
                 i, bus.mouse_x, bus.mouse_y, bus.moved, bus.mouse_left);
      end
    end
    vec_cnt++;
    if (bus.dbg_state !== 1'b1) begin
      err_cnt++;
      $display("FAIL primed_state: got %b required 1", bus.dbg_state);
    end
  endtask

  task automatic test_basic();
    do_reset(1'b0);
    step(1'b1, 8'h05, 8'd20, 8'h0A, 1'b0, 1'b0);   // L+M, X=+20, Y=+10 -> -10
    vec_cnt++;
    if (bus.dbg_acc_x !== 14'sd20 || bus.dbg_acc_y !== -14'sd10 || bus.mouse_x !== 9'sd0) begin
      err_cnt++;
      $display("FAIL basic_acc: accx=%0d accy=%0d x=%0d, required 20 -10 0",
               bus.dbg_acc_x, bus.dbg_acc_y, bus.mouse_x);
    end
    vec_cnt++;
    if ({bus.mouse_left, bus.mouse_middle, bus.mouse_right} !== 3'b110) begin
      err_cnt++;
      $display("FAIL basic_buttons: lmr=%b required 110",
               {bus.mouse_left, bus.mouse_middle, bus.mouse_right});
    end
    idle(1);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd20 || bus.mouse_y !== -9'sd10 || bus.moved !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_out: x=%0d y=%0d moved=%b, required 20 -10 1",
               bus.mouse_x, bus.mouse_y, bus.moved);
    end
    step(1'b1, 8'h02, 8'd0, 8'd0, 1'b0, 1'b0);     // right only, zero motion
    vec_cnt++;
    if ({bus.mouse_left, bus.mouse_middle, bus.mouse_right} !== 3'b001 ||
        bus.dbg_acc_x !== 14'sd20) begin
      err_cnt++;
      $display("FAIL buttons_update: lmr=%b accx=%0d, required 001 20",
               {bus.mouse_left, bus.mouse_middle, bus.mouse_right}, bus.dbg_acc_x);
    end
    step(1'b1, 8'h20, 8'd0, 8'h00, 1'b0, 1'b0);    // Y=-256 inverts to +255
    vec_cnt++;
    if (bus.dbg_acc_y !== 14'sd245) begin
      err_cnt++;
      $display("FAIL inv_neg256: accy=%0d required 245", bus.dbg_acc_y);
    end
    step(1'b1, 8'h80, 8'd0, 8'h37, 1'b0, 1'b0);    // Yovf, sign 0 -> +255 -> -255
    vec_cnt++;
    if (bus.dbg_acc_y !== -14'sd10) begin
      err_cnt++;
      $display("FAIL yovf_pos: accy=%0d required -10", bus.dbg_acc_y);
    end
    idle(1);
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1);
    vec_cnt++;
    if (bus.dbg_acc_x !== 14'sd0 || bus.dbg_acc_y !== 14'sd0) begin
      err_cnt++;
      $display("FAIL drain_both: accx=%0d accy=%0d, required 0 0", bus.dbg_acc_x, bus.dbg_acc_y);
    end
    idle(1);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd0 || bus.mouse_y !== 9'sd0 || bus.moved !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_out: x=%0d y=%0d moved=%b, required 0 0 0",
               bus.mouse_x, bus.mouse_y, bus.moved);
    end
  endtask

  task automatic test_drain();
    logic signed [8:0] exp_out[4];
    logic signed [13:0] e;
    do_reset(1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h00, 8'd200, 8'h00, 1'b0, 1'b0);
    vec_cnt++;
    if (bus.dbg_acc_x !== 14'sd1000) begin
      err_cnt++;
      $display("FAIL drain_fill: accx=%0d required 1000", bus.dbg_acc_x);
    end
    exp_q = {14'sd745, 14'sd490, 14'sd235, 14'sd0};
    exp_out = '{9'sd255, 9'sd255, 9'sd255, 9'sd235};
    for (int i = 0; i < 4; i++) begin
      idle(1);
      vec_cnt++;
      if (bus.mouse_x !== exp_out[i]) begin
        err_cnt++;
        $display("FAIL drain_out %0d: x=%0d required %0d", i, bus.mouse_x, exp_out[i]);
      end
      step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
      e = exp_q.pop_front();
      vec_cnt++;
      if (bus.dbg_acc_x !== e) begin
        err_cnt++;
        $display("FAIL drain_residual %0d: accx=%0d required %0d", i, bus.dbg_acc_x, e);
      end
    end
    idle(1);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd0 || bus.moved !== 1'b0) begin
      err_cnt++;
      $display("FAIL drain_empty: x=%0d moved=%b, required 0 0", bus.mouse_x, bus.moved);
    end
  endtask

  task automatic test_overflow_same_edge();
    do_reset(1'b0);
    step(1'b1, 8'h50, 8'h12, 8'h00, 1'b0, 1'b0);   // Xovf with sign -> -256
    vec_cnt++;
    if (bus.dbg_acc_x !== -14'sd256) begin
      err_cnt++;
      $display("FAIL xovf_neg: accx=%0d required -256", bus.dbg_acc_x);
    end
    idle(1);
    vec_cnt++;
    if (bus.mouse_x !== -9'sd256) begin
      err_cnt++;
      $display("FAIL xovf_out: x=%0d required -256", bus.mouse_x);
    end
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);
    step(1'b1, 8'h00, 8'd50, 8'h00, 1'b0, 1'b0);
    idle(1);
    step(1'b1, 8'h00, 8'd7, 8'h00, 1'b1, 1'b0);    // acc=50,out=50,d=+7 same edge
    vec_cnt++;
    if (bus.dbg_acc_x !== 14'sd7) begin
      err_cnt++;
      $display("FAIL same_edge: accx=%0d required 7", bus.dbg_acc_x);
    end
    idle(1);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd7) begin
      err_cnt++;
      $display("FAIL same_edge_out: x=%0d required 7", bus.mouse_x);
    end
    step(1'b1, 8'h00, 8'd30, 8'h00, 1'b0, 1'b0);   // acc 37, out still 7
    step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0);   // subtracts old out 7
    vec_cnt++;
    if (bus.dbg_acc_x !== 14'sd30) begin
      err_cnt++;
      $display("FAIL consume_after_pkt: accx=%0d required 30", bus.dbg_acc_x);
    end
  endtask

  task automatic test_saturate();
    logic wrapped;
    do_reset(1'b1);
    wrapped = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 8'h00, 8'hFF, 8'hFF, 1'b0, 1'b0);  // X +255, Y +255 -> -255
      if (bus.dbg_acc_x[13] !== 1'b0 || bus.dbg_acc_y > 14'sd0) wrapped = 1'b1;
    end
    vec_cnt++;
    if (wrapped !== 1'b0 || bus.dbg_acc_x !== 14'sd8191 || bus.dbg_acc_y !== -14'sd8192) begin
      err_cnt++;
      $display("FAIL sat_pos: wrapped=%b accx=%0d accy=%0d, required 0 8191 -8192",
               wrapped, bus.dbg_acc_x, bus.dbg_acc_y);
    end
    idle(1);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd255 || bus.mouse_y !== -9'sd256) begin
      err_cnt++;
      $display("FAIL sat_out: x=%0d y=%0d, required 255 -256", bus.mouse_x, bus.mouse_y);
    end
    for (int i = 0; i < 70; i++) step(1'b1, 8'h50, 8'h00, 8'h00, 1'b0, 1'b0);
    vec_cnt++;
    if (bus.dbg_acc_x !== -14'sd8192) begin
      err_cnt++;
      $display("FAIL sat_neg: accx=%0d required -8192", bus.dbg_acc_x);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tog = ~tog;
    bus.ps2_mouse = {tog, 8'd0, 8'd9, 8'h01};   // toggle moves while in reset
    @(negedge clk_sys);
    reset = 1'b0;
    idle(5);
    vec_cnt++;
    if (bus.dbg_acc_x !== 14'sd0 || bus.dbg_acc_y !== 14'sd0 || bus.mouse_x !== 9'sd0 ||
        bus.moved !== 1'b0 || bus.mouse_left !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid: accx=%0d accy=%0d x=%0d moved=%b left=%b, required all 0",
               bus.dbg_acc_x, bus.dbg_acc_y, bus.mouse_x, bus.moved, bus.mouse_left);
    end
    step(1'b1, 8'h00, 8'd3, 8'h00, 1'b0, 1'b0);
    vec_cnt++;
    if (bus.dbg_acc_x !== 14'sd3) begin
      err_cnt++;
      $display("FAIL after_reset_pkt: accx=%0d required 3", bus.dbg_acc_x);
    end
  endtask

  task automatic test_stale();
    do_reset(1'b0);
    step(1'b1, 8'h01, 8'd5, 8'h00, 1'b0, 1'b0);
    idle(16);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd5) begin
      err_cnt++;
      $display("FAIL stale_hold16: x=%0d required 5", bus.mouse_x);
    end
    idle(1);
`ifdef AMX_STALE_CLEAR_EN
    vec_cnt++;
    if (bus.mouse_x !== 9'sd0 || bus.mouse_left !== 1'b1) begin
      err_cnt++;
      $display("FAIL stale_clear: x=%0d left=%b, required 0 1", bus.mouse_x, bus.mouse_left);
    end
`else
    idle(40);
    vec_cnt++;
    if (bus.mouse_x !== 9'sd5 || bus.moved !== 1'b1 || bus.mouse_left !== 1'b1) begin
      err_cnt++;
      $display("FAIL stale_none: x=%0d moved=%b left=%b, required 5 1 1",
               bus.mouse_x, bus.moved, bus.mouse_left);
    end
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ps2_mouse = '0;
    bus.consume_x = 1'b0;
    bus.consume_y = 1'b0;
    test_reset();
    test_basic();
    test_drain();
    test_overflow_same_edge();
    test_saturate();
    test_reset_mid();
    test_stale();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
